// File: rtl/pulse_divider_pkg.sv
// Shared types and constants for the multi-channel pulse divider.
package pulse_divider_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        DONE = 2'd1,
        IDLE = 2'd2
    } div_state_t;

    localparam int STATE_WIDTH = 2;

    // Wide constants; sliced to the word width where used.
    localparam logic [63:0] WORD_ZERO = 64'd0;
    localparam logic [63:0] WORD_ONE  = 64'd1;

endpackage

// File: rtl/pulse_divider_channel.sv
// One divider channel: RUN/DONE/IDLE FSM, down-counter and optional quotient
// counter (enabled by QUOTIENT_COUNT_EN).
module pulse_divider_channel
    import pulse_divider_pkg::*;
#(
    parameter int                    WORD_WIDTH      = 16,
    parameter logic [WORD_WIDTH-1:0] INITIAL_DIVISOR = WORD_WIDTH'(3),
    parameter int                    QUOTIENT_WIDTH  = 8
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      restart,
    input  logic                      oneshot,
    input  logic [WORD_WIDTH-1:0]     divisor,
    input  logic                      pulse_in,
    output logic                      pulse_out,
    output logic                      done,
    output logic [QUOTIENT_WIDTH-1:0] quotient,
    output logic [STATE_WIDTH-1:0]    state_dbg
);

    localparam logic [WORD_WIDTH-1:0] W_ZERO     = WORD_ZERO[WORD_WIDTH-1:0];
    localparam logic [WORD_WIDTH-1:0] W_ONE      = WORD_ONE[WORD_WIDTH-1:0];
    localparam div_state_t            INIT_STATE = (INITIAL_DIVISOR == W_ZERO) ? IDLE : RUN;

    div_state_t            state, state_next;
    logic [WORD_WIDTH-1:0] remaining, remaining_next;
    logic                  pulse_next;
    div_state_t            reload_state;

    // A zero divisor parks the channel in IDLE until a non-zero value appears.
    assign reload_state = (divisor == W_ZERO) ? IDLE : RUN;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= INIT_STATE;
            remaining <= INITIAL_DIVISOR;
            pulse_out <= 1'b0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            pulse_out <= pulse_next;
        end
    end

    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        pulse_next     = 1'b0;
        if (restart) begin
            remaining_next = divisor;
            state_next     = reload_state;
        end else begin
            case (state)
                RUN: begin
                    if (pulse_in) begin
                        if (remaining == W_ONE) begin
                            pulse_next     = 1'b1;
                            remaining_next = divisor;
                            state_next     = oneshot ? DONE : reload_state;
                        end else begin
                            remaining_next = remaining - W_ONE;
                        end
                    end
                end
                IDLE: begin
                    remaining_next = divisor;
                    state_next     = reload_state;
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign done      = (state == DONE);
    assign state_dbg = state;

`ifdef QUOTIENT_COUNT_EN
    // Counts terminal counts; saturates rather than wrapping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            quotient <= '0;
        end else if (restart) begin
            quotient <= '0;
        end else if (pulse_next && !(&quotient)) begin
            quotient <= quotient + 1'b1;
        end
    end
`else
    assign quotient = '0;
`endif

endmodule

// File: rtl/pulse_divider_multi.sv
// CHANNELS independent pulse dividers sharing one clock; flat buses sliced per
// channel. Optional per-channel quotient counters under QUOTIENT_COUNT_EN.
module pulse_divider_multi
    import pulse_divider_pkg::*;
#(
    parameter int                    CHANNELS        = 4,
    parameter int                    WORD_WIDTH      = 16,
    parameter logic [WORD_WIDTH-1:0] INITIAL_DIVISOR = WORD_WIDTH'(3),
    parameter int                    QUOTIENT_WIDTH  = 8
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic [CHANNELS-1:0]                restart,
    input  logic [CHANNELS-1:0]                oneshot,
    input  logic [CHANNELS*WORD_WIDTH-1:0]     divisor,
    input  logic [CHANNELS-1:0]                pulses_in,
    output logic [CHANNELS-1:0]                pulse_out,
    output logic [CHANNELS-1:0]                done,
    output logic [CHANNELS*QUOTIENT_WIDTH-1:0] quotient,
    output logic [CHANNELS*STATE_WIDTH-1:0]    state_dbg
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        pulse_divider_channel #(
            .WORD_WIDTH      (WORD_WIDTH),
            .INITIAL_DIVISOR (INITIAL_DIVISOR),
            .QUOTIENT_WIDTH  (QUOTIENT_WIDTH)
        ) u_chan (
            .clock     (clock),
            .reset_n   (reset_n),
            .restart   (restart[c]),
            .oneshot   (oneshot[c]),
            .divisor   (divisor[c*WORD_WIDTH +: WORD_WIDTH]),
            .pulse_in  (pulses_in[c]),
            .pulse_out (pulse_out[c]),
            .done      (done[c]),
            .quotient  (quotient[c*QUOTIENT_WIDTH +: QUOTIENT_WIDTH]),
            .state_dbg (state_dbg[c*STATE_WIDTH +: STATE_WIDTH])
        );
    end

endmodule

// File: tb/tb_pulse_divider_multi.sv
// Directed bench for pulse_divider_multi with hand-computed expectations.
module tb_pulse_divider_multi;

    localparam int CH = 4;
    localparam int W  = 16;
    localparam int QW = 8;
    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_DONE = 2'd1;
    localparam logic [1:0] S_IDLE = 2'd2;

    logic             clock;
    logic             reset_n;
    logic [CH-1:0]    restart;
    logic [CH-1:0]    oneshot;
    logic [CH*W-1:0]  divisor;
    logic [CH-1:0]    pulses_in;
    logic [CH-1:0]    pulse_out;
    logic [CH-1:0]    done;
    logic [CH*QW-1:0] quotient;
    logic [CH*2-1:0]  state_dbg;

    int total;
    int bad;

    pulse_divider_multi #(
        .CHANNELS        (CH),
        .WORD_WIDTH      (W),
        .INITIAL_DIVISOR (16'd3),
        .QUOTIENT_WIDTH  (QW)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .restart   (restart),
        .oneshot   (oneshot),
        .divisor   (divisor),
        .pulses_in (pulses_in),
        .pulse_out (pulse_out),
        .done      (done),
        .quotient  (quotient),
        .state_dbg (state_dbg)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_div(input int c, input int v);
        divisor[c*W +: W] = W'(v);
    endtask

    function automatic logic [QW-1:0] qexp(input int n);
`ifdef QUOTIENT_COUNT_EN
        return QW'(n);
`else
        return '0;
`endif
    endfunction

    task automatic test_reset();
        reset_n   = 1'b0;
        restart   = '0;
        oneshot   = '0;
        pulses_in = '0;
        for (int c = 0; c < CH; c++) set_div(c, 3);
        repeat (3) tick();
        total++;
        if (pulse_out !== 4'b0000) begin
            bad++; $display("FAIL reset_pulse_out: got %b want 0000", pulse_out);
        end
        total++;
        if (done !== 4'b0000) begin
            bad++; $display("FAIL reset_done: got %b want 0000", done);
        end
        total++;
        if (quotient !== 32'h0) begin
            bad++; $display("FAIL reset_quotient: got %h want 0", quotient);
        end
        total++;
        if (state_dbg !== 8'h00) begin
            bad++; $display("FAIL reset_state: got %h want 00", state_dbg);
        end
        reset_n = 1'b1;
        tick();
        total++;
        if (state_dbg !== 8'h00 || pulse_out !== 4'b0000) begin
            bad++; $display("FAIL reset_release: state %h pulse %b want 00 0000", state_dbg, pulse_out);
        end
    endtask

    task automatic test_periodic();
        logic [CH-1:0] exp_p;
        for (int i = 1; i <= 9; i++) begin
            pulses_in = 4'b0001;
            tick();
            exp_p = (i % 3 == 0) ? 4'b0001 : 4'b0000;
            total++;
            if (pulse_out !== exp_p) begin
                bad++; $display("FAIL periodic_pulse[%0d]: got %b want %b", i, pulse_out, exp_p);
            end
        end
        pulses_in = '0;
        tick();
        total++;
        if (pulse_out !== 4'b0000) begin
            bad++; $display("FAIL periodic_idle: got %b want 0000", pulse_out);
        end
        total++;
        if (quotient[0 +: QW] !== qexp(3)) begin
            bad++; $display("FAIL periodic_quotient: got %0d want %0d", quotient[0 +: QW], qexp(3));
        end
    endtask

    task automatic test_oneshot();
        set_div(1, 2);
        oneshot[1] = 1'b1;
        restart[1] = 1'b1;
        tick();
        restart[1] = 1'b0;
        total++;
        if (done[1] !== 1'b0 || quotient[QW +: QW] !== 8'd0) begin
            bad++; $display("FAIL oneshot_start: done %b quotient %0d want 0 0", done[1], quotient[QW +: QW]);
        end
        for (int i = 1; i <= 6; i++) begin
            pulses_in[1] = 1'b1;
            tick();
            total++;
            if (pulse_out[1] !== 1'(i == 2) || done[1] !== 1'(i >= 2)) begin
                bad++; $display("FAIL oneshot_pulse[%0d]: pulse %b done %b want %b %b",
                                i, pulse_out[1], done[1], 1'(i == 2), 1'(i >= 2));
            end
        end
        pulses_in[1] = 1'b0;
        tick();
        total++;
        if (state_dbg[3:2] !== S_DONE || quotient[QW +: QW] !== qexp(1)) begin
            bad++; $display("FAIL oneshot_halt: state %0d quotient %0d want %0d %0d",
                            state_dbg[3:2], quotient[QW +: QW], S_DONE, qexp(1));
        end
        restart[1] = 1'b1;
        tick();
        restart[1] = 1'b0;
        total++;
        if (done[1] !== 1'b0 || quotient[QW +: QW] !== 8'd0 || pulse_out[1] !== 1'b0) begin
            bad++; $display("FAIL oneshot_restart: done %b quotient %0d pulse %b want 0 0 0",
                            done[1], quotient[QW +: QW], pulse_out[1]);
        end
        for (int i = 1; i <= 2; i++) begin
            pulses_in[1] = 1'b1;
            tick();
            total++;
            if (pulse_out[1] !== 1'(i == 2)) begin
                bad++; $display("FAIL oneshot_second[%0d]: got %b want %b", i, pulse_out[1], 1'(i == 2));
            end
        end
        pulses_in[1] = 1'b0;
        tick();
        total++;
        if (done[1] !== 1'b1) begin
            bad++; $display("FAIL oneshot_second_done: got %b want 1", done[1]);
        end
        oneshot[1] = 1'b0;
    endtask

    task automatic test_restart_drop();
        set_div(2, 4);
        restart[2] = 1'b1;
        tick();
        restart[2] = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            pulses_in[2] = 1'b1;
            tick();
            total++;
            if (pulse_out[2] !== 1'b0) begin
                bad++; $display("FAIL restart_pre[%0d]: got %b want 0", i, pulse_out[2]);
            end
        end
        restart[2]   = 1'b1;
        pulses_in[2] = 1'b1;
        tick();
        restart[2] = 1'b0;
        total++;
        if (pulse_out[2] !== 1'b0) begin
            bad++; $display("FAIL restart_same_cycle: got %b want 0", pulse_out[2]);
        end
        for (int i = 1; i <= 4; i++) begin
            pulses_in[2] = 1'b1;
            tick();
            total++;
            if (pulse_out[2] !== 1'(i == 4)) begin
                bad++; $display("FAIL restart_post[%0d]: got %b want %b", i, pulse_out[2], 1'(i == 4));
            end
        end
        pulses_in[2] = 1'b0;
    endtask

    task automatic test_zero_divisor();
        set_div(3, 0);
        restart[3] = 1'b1;
        tick();
        restart[3] = 1'b0;
        total++;
        if (state_dbg[7:6] !== S_IDLE) begin
            bad++; $display("FAIL zero_idle_state: got %0d want %0d", state_dbg[7:6], S_IDLE);
        end
        pulses_in[3] = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            total++;
            if (pulse_out[3] !== 1'b0) begin
                bad++; $display("FAIL zero_pulse[%0d]: got %b want 0", i, pulse_out[3]);
            end
        end
        set_div(3, 5);
        tick();
        total++;
        if (pulse_out[3] !== 1'b0 || state_dbg[7:6] !== S_RUN) begin
            bad++; $display("FAIL zero_reload: pulse %b state %0d want 0 %0d", pulse_out[3], state_dbg[7:6], S_RUN);
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            total++;
            if (pulse_out[3] !== 1'(i == 5)) begin
                bad++; $display("FAIL zero_count[%0d]: got %b want %b", i, pulse_out[3], 1'(i == 5));
            end
        end
        pulses_in[3] = 1'b0;
    endtask

    task automatic test_all_channels();
        int cnt [CH];
        int exp_cnt [CH];
        exp_cnt = '{42, 21, 14, 6};
        set_div(0, 1); set_div(1, 2); set_div(2, 3); set_div(3, 7);
        oneshot = '0;
        restart = 4'hf;
        tick();
        restart = '0;
        for (int c = 0; c < CH; c++) cnt[c] = 0;
        pulses_in = 4'hf;
        for (int i = 1; i <= 42; i++) begin
            tick();
            for (int c = 0; c < CH; c++) cnt[c] += int'(pulse_out[c]);
            total++;
            if (pulse_out[0] !== 1'b1) begin
                bad++; $display("FAIL all_div1_follow[%0d]: got %b want 1", i, pulse_out[0]);
            end
        end
        pulses_in = '0;
        tick();
        total++;
        if (pulse_out !== 4'b0000) begin
            bad++; $display("FAIL all_stop: got %b want 0000", pulse_out);
        end
        for (int c = 0; c < CH; c++) begin
            total++;
            if (cnt[c] !== exp_cnt[c]) begin
                bad++; $display("FAIL all_count[%0d]: got %0d want %0d", c, cnt[c], exp_cnt[c]);
            end
            total++;
            if (quotient[c*QW +: QW] !== qexp(exp_cnt[c])) begin
                bad++; $display("FAIL all_quotient[%0d]: got %0d want %0d", c, quotient[c*QW +: QW], qexp(exp_cnt[c]));
            end
        end
    endtask

    task automatic test_reset_mid_count();
        set_div(0, 3);
        restart[0] = 1'b1;
        tick();
        restart[0] = 1'b0;
        set_div(0, 5);
        for (int i = 1; i <= 2; i++) begin
            pulses_in[0] = 1'b1;
            tick();
        end
        pulses_in[0] = 1'b1;
        reset_n      = 1'b0;
        #2;
        total++;
        if (pulse_out !== 4'b0000) begin
            bad++; $display("FAIL midreset_async: got %b want 0000", pulse_out);
        end
        tick();
        total++;
        if (pulse_out !== 4'b0000 || quotient !== 32'h0 || state_dbg !== 8'h00) begin
            bad++; $display("FAIL midreset_hold: pulse %b quotient %h state %h want 0000 0 00",
                            pulse_out, quotient, state_dbg);
        end
        reset_n   = 1'b1;
        pulses_in = '0;
        tick();
        for (int i = 1; i <= 3; i++) begin
            pulses_in[0] = 1'b1;
            tick();
            total++;
            if (pulse_out[0] !== 1'(i == 3)) begin
                bad++; $display("FAIL midreset_init[%0d]: got %b want %b", i, pulse_out[0], 1'(i == 3));
            end
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            total++;
            if (pulse_out[0] !== 1'(i == 5)) begin
                bad++; $display("FAIL midreset_reload[%0d]: got %b want %b", i, pulse_out[0], 1'(i == 5));
            end
        end
        pulses_in = '0;
        tick();
        total++;
        if (quotient[0 +: QW] !== qexp(2)) begin
            bad++; $display("FAIL midreset_quotient: got %0d want %0d", quotient[0 +: QW], qexp(2));
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_periodic();
        test_oneshot();
        test_restart_drop();
        test_zero_divisor();
        test_all_channels();
        test_reset_mid_count();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
